tmds_lane_gearbox: RTL
======================

// Module: tmds_lane_gearbox
// PURPOSE
//  Parametrised N-channel word-to-lane serializer (gearbox), successor to the fixed 3x10b DDR serializer.
//  Accepts CHANNELS parallel words per ready/valid handshake and emits LANE_BITS bits/channel/clock.
//  Inserts IDLE_WORD on starvation and flags it. Sits between TMDS encoders and the output DDR/SDR pads.
//  Everything is in the serclk domain.
// PARAMETERS
//  CHANNELS   3              number of data channels
//  WORD_W     10             bits per channel word (TMDS symbol width)
//  LANE_BITS  2              bits per channel per clock: 1 = SDR, 2 = DDR (bit0 = rising, bit1 = falling)
//  IDLE_WORD  10'b1101010100 word sent on all channels when no data (TMDS control token C1C0=00)
//  Legal: LANE_BITS in {1,2}; WORD_W % LANE_BITS == 0; SLOTS = WORD_W/LANE_BITS >= 2; WORD_W even.
// PORTS
//  serclk      in   1                   serial/lane clock
//  rst_n       in   1                   asynchronous reset, active low
//  in_valid    in   1                   in_data holds a word set
//  in_ready    out  1                   word set accepted on in_valid && in_ready
//  in_data     in   CHANNELS*WORD_W     channel j at [j*WORD_W +: WORD_W]
//  lane_out    out  CHANNELS*LANE_BITS  channel j at [j*LANE_BITS +: LANE_BITS]
//  word_start  out  1                   high while lane_out carries slot 0 of a word
//  underflow   out  1                   one-cycle pulse, aligned to slot 0 of an inserted idle word
//  clk_lane    out  LANE_BITS           TMDS clock-lane pattern (present only with TMDS_CLK_LANE_EN)
// BEHAVIOUR
//  - slot counter 0..SLOTS-1, increments each clock, wraps SLOTS-1 -> 0. word_start = (slot == 0).
//  - Per-channel shift reg sh[j]; lane_out[j] = sh[j][LANE_BITS-1:0] (direct from flops), LSB first.
//  - slot != SLOTS-1: sh >>= LANE_BITS. slot == SLOTS-1 (load cycle): sh loaded with the next word set.
//  - One-entry holding reg (hold, hold_valid). in_ready = !hold_valid || (slot == SLOTS-1).
//  - Load-cycle source priority: hold (if hold_valid) > in_data (if accepted this cycle, bypass) > IDLE_WORD.
//  - Load with hold_valid and accept: hold -> sh, in_data -> hold, hold_valid stays 1.
//  - Load with hold_valid, no accept: hold -> sh, hold_valid <= 0.
//  - Non-load accept: in_data -> hold, hold_valid <= 1 (in_ready was 1, so hold was empty).
//  - Load with IDLE source: underflow <= 1 for next cycle (slot 0); otherwise underflow <= 0.
//  - Latency accept -> slot 0 on lane_out: 1 clock (bypass in load cycle) up to SLOTS clocks (accepted at slot 0).
//  - Words emitted strictly in acceptance order; none dropped or duplicated; back-to-back stream has no gaps.
//  - Reset (async, immediate): slot=0, sh[j]=IDLE_WORD, hold_valid=0, underflow=0.
//    Outputs in reset: lane_out = IDLE_WORD[LANE_BITS-1:0] on all channels, word_start=1, in_ready=1,
//    underflow=0. The reset-idle word does not pulse underflow.
//  - Reset mid-word: partial word and held word discarded, never emitted; restart at slot 0 on release.
//  - in_data/in_valid ignored while rst_n low.
// CONFIGURATION
//  TMDS_CLK_LANE_EN defined: clk_lane port present; clk_lane = bits [slot*LANE_BITS +: LANE_BITS] of the
//    pattern P, P[i] = (i < WORD_W/2), i.e. 1111100000 sent LSB first. Registered, slot-aligned with
//    lane_out; reset value P[LANE_BITS-1:0].
//  Not defined: no clk_lane port and no pattern logic; the pixel clock is forwarded externally.
// TESTING (CHANNELS=3, WORD_W=10, LANE_BITS=2, default IDLE_WORD unless noted)
//  1 Reset release, in_valid=0 -> lane_out = IDLE pairs 00,01,01,01,11 repeating every 5 clks;
//    underflow pulses at each slot 0 from the 2nd word on, never on the reset-idle word.
//  2 One set {ch2=0x155, ch1=0x000, ch0=0x3FF} presented only in the slot-4 cycle, hold empty -> accepted
//    (bypass); next 5 clks ch0=11, ch1=00, ch2=01; word_start on the 1st; no underflow for that word.
//  3 in_valid held high, incrementing data -> consecutive words out in order, no idle, underflow never;
//    in_ready low on slots 0-3 whenever hold is full.
//  4 Word A presented at slot 0 -> accepted into hold, in_ready low slots 1-3. Word B presented ->
//    accepted at slot 4 as A moves to sh. A emitted, then B.
//  5 rst_n low at slot 2 with a word in hold -> lane_out = IDLE slot-0 bits, in_ready=1 at once;
//    after release the discarded words never appear.
//  6 LANE_BITS=1, TMDS_CLK_LANE_EN -> clk_lane 1 for 5 clks then 0 for 5; word_start every 10 clks,
//    coincident with the first 1.

Source files
------------

// File: rtl/tmds_lane_gearbox.sv
// N-channel word-to-lane gearbox: serializes CHANNELS words of WORD_W bits into LANE_BITS bits per clock.
// Optional TMDS clock-lane pattern output when TMDS_CLK_LANE_EN is defined.
module tmds_lane_gearbox #(
  parameter int                CHANNELS  = 3,
  parameter int                WORD_W    = 10,
  parameter int                LANE_BITS = 2,
  parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100
) (
  input  logic                          serclk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WORD_W-1:0]    in_data,
  output logic [CHANNELS*LANE_BITS-1:0] lane_out,
  output logic                          word_start,
  output logic                          underflow
`ifdef TMDS_CLK_LANE_EN
  ,
  output logic [LANE_BITS-1:0]          clk_lane
`endif
);

  localparam int SLOTS = WORD_W / LANE_BITS;
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  logic [SW-1:0]               slot;
  logic [WORD_W-1:0]           sh [CHANNELS];
  logic [CHANNELS*WORD_W-1:0]  hold;
  logic                        hold_valid;
  logic                        load;
  logic                        accept;

  // Handshake: a word set transfers on a clock edge where in_valid && in_ready; the
  // source may change in_data freely while in_valid is low, and in_ready never depends on in_valid.
  assign load       = (slot == LAST_SLOT);
  assign in_ready   = !hold_valid || load;
  assign accept     = in_valid && in_ready;
  assign word_start = (slot == '0);

  for (genvar j = 0; j < CHANNELS; j++) begin : g_lane
    assign lane_out[j*LANE_BITS +: LANE_BITS] = sh[j][LANE_BITS-1:0];
  end

  always_ff @(posedge serclk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      underflow  <= 1'b0;
      for (int j = 0; j < CHANNELS; j++) sh[j] <= IDLE_WORD;
    end else begin
      slot      <= load ? '0 : slot + SW'(1);
      underflow <= 1'b0;
      if (load) begin
        // Held word is older than anything arriving now, so it always goes first.
        if (hold_valid) begin
          for (int j = 0; j < CHANNELS; j++) sh[j] <= hold[j*WORD_W +: WORD_W];
          if (accept) hold <= in_data;
          else        hold_valid <= 1'b0;
        end else if (accept) begin
          for (int j = 0; j < CHANNELS; j++) sh[j] <= in_data[j*WORD_W +: WORD_W];
        end else begin
          for (int j = 0; j < CHANNELS; j++) sh[j] <= IDLE_WORD;
          underflow <= 1'b1;
        end
      end else begin
        for (int j = 0; j < CHANNELS; j++) sh[j] <= sh[j] >> LANE_BITS;
        if (accept) begin
          hold       <= in_data;
          hold_valid <= 1'b1;
        end
      end
    end
  end

`ifdef TMDS_CLK_LANE_EN
  function automatic logic [WORD_W-1:0] clk_pattern();
    logic [WORD_W-1:0] p;
    for (int i = 0; i < WORD_W; i++) p[i] = (i < WORD_W / 2);
    return p;
  endfunction

  localparam logic [WORD_W-1:0] CLK_PAT = clk_pattern();

  // Runs in lockstep with the data shift registers so clk_lane stays slot-aligned.
  logic [WORD_W-1:0] clk_sh;

  always_ff @(posedge serclk or negedge rst_n) begin
    if (!rst_n) clk_sh <= CLK_PAT;
    else        clk_sh <= load ? CLK_PAT : (clk_sh >> LANE_BITS);
  end

  assign clk_lane = clk_sh[LANE_BITS-1:0];
`endif

endmodule
